// File: rtl/instruction_fetch_if.sv
// Instruction-fetch bundle: memory read channel plus the decode-side
// instruction handoff. The fetch unit uses the master view; memory/decode
// models use the slave view.
interface instruction_fetch_if;
  logic        memReadRequest;
  logic [31:0] memAddress;
  logic        memReadReady;
  logic        memReadValid;
  logic [31:0] memReadData;
  logic        stall;
  logic        redirect;
  logic [31:0] redirectAddress;
  logic [31:0] instructionData;
  logic [31:0] instructionAddress;
  logic [31:0] nextPCAddress;
  logic        instructionValid;

  modport master (
    output memReadRequest, memAddress,
    output instructionData, instructionAddress, nextPCAddress, instructionValid,
    input  memReadReady, memReadValid, memReadData,
    input  stall, redirect, redirectAddress
  );

  modport slave (
    input  memReadRequest, memAddress,
    input  instructionData, instructionAddress, nextPCAddress, instructionValid,
    output memReadReady, memReadValid, memReadData,
    output stall, redirect, redirectAddress
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: issues word-aligned reads to instruction memory,
// buffers returned words with their addresses in a small FIFO, and hands
// them to the decode stage. A redirect flushes the buffer and marks every
// outstanding read for discard so stale words never reach decode.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic                clk,
  input  logic                rst,
  instruction_fetch_if.master bus
);

  localparam logic [1:0] ST_RESET_HOLD = 2'd0;
  localparam logic [1:0] ST_FETCH      = 2'd1;
  localparam logic [1:0] ST_REDIRECT   = 2'd2;

  // Storage is sized for the largest legal depth; pointers wrap at the
  // configured depth so non-power-of-two depths work.
  localparam int         DEPTH    = 4;
  localparam logic [3:0] MAX_CNT  = 4'(MAX_OUTSTANDING);
  localparam logic [1:0] LAST_IDX = 2'(MAX_OUTSTANDING - 1);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [2:0]  inflight_q, inflight_d;   // live reads awaiting data
  logic [3:0]  discard_q, discard_d;     // reads whose data must be dropped
  logic [2:0]  cnt_q, cnt_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [31:0] data_q [DEPTH];
  logic [31:0] addr_q [DEPTH];

  logic [3:0]  occupancy;
  logic [4:0]  outstanding;
  logic        req;
  logic        accept;
  logic        push;
  logic        pop;
  logic        drop_discard;
  logic        head_vld;
  logic [31:0] rsp_addr;
  logic [31:0] redirect_pc;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    if (p == LAST_IDX) return 2'd0;
    return p + 2'd1;
  endfunction

  assign occupancy    = {1'b0, inflight_q} + {1'b0, cnt_q};
  assign outstanding  = {1'b0, discard_q} + {2'b00, inflight_q};
  assign req          = (state_q == ST_FETCH) && !bus.redirect && (occupancy < MAX_CNT);
  assign accept       = req && bus.memReadReady;
  // Responses retire discards first; with nothing live in flight a stray
  // response is simply ignored.
  assign drop_discard = bus.memReadValid && !bus.redirect && (discard_q != 4'd0);
  assign push         = bus.memReadValid && !bus.redirect && (discard_q == 4'd0) &&
                        (inflight_q != 3'd0);
  assign pop          = head_vld && !bus.stall && !bus.redirect;
  // Live reads are consecutive words ending just below the PC, so the
  // oldest one (the one returning now) sits inflight_q words back.
  assign rsp_addr     = pc_q - {27'd0, inflight_q, 2'b00};
  assign redirect_pc  = bus.redirectAddress & 32'hFFFF_FFFC;

  // Next-state logic: redirect overrides fetch, push and pop.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inflight_d = inflight_q;
    discard_d  = discard_q;
    cnt_d      = cnt_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    if (bus.redirect) begin
      state_d    = ST_REDIRECT;
      pc_d       = redirect_pc;
      inflight_d = 3'd0;
      cnt_d      = 3'd0;
      rd_ptr_d   = 2'd0;
      wr_ptr_d   = 2'd0;
      // A response arriving with the redirect retires one outstanding read.
      if (bus.memReadValid && (outstanding != 5'd0)) begin
        discard_d = 4'(outstanding - 5'd1);
      end else begin
        discard_d = 4'(outstanding);
      end
    end else begin
      case (state_q)
        ST_RESET_HOLD: state_d = ST_FETCH;
        ST_REDIRECT:   state_d = ST_FETCH;
        default:       state_d = ST_FETCH;
      endcase
      if (accept) pc_d = pc_q + 32'd4;
      inflight_d = inflight_q + {2'b00, accept} - {2'b00, push};
      if (drop_discard) discard_d = discard_q - 4'd1;
      cnt_d = cnt_q + {2'b00, push} - {2'b00, pop};
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    end
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_RESET_HOLD;
      pc_q       <= RESET_PC;
      inflight_q <= 3'd0;
      discard_q  <= 4'd0;
      cnt_q      <= 3'd0;
      rd_ptr_q   <= 2'd0;
      wr_ptr_q   <= 2'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      cnt_q      <= cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // FIFO payload; contents are only visible through a non-zero count.
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr_q] <= bus.memReadData;
      addr_q[wr_ptr_q] <= rsp_addr;
    end
  end

  assign head_vld               = (cnt_q != 3'd0);
  assign bus.memReadRequest     = req;
  assign bus.memAddress         = pc_q;
  assign bus.instructionValid   = head_vld;
  assign bus.instructionData    = head_vld ? data_q[rd_ptr_q] : 32'h0;
  assign bus.instructionAddress = head_vld ? addr_q[rd_ptr_q] : 32'h0;
  assign bus.nextPCAddress      = head_vld ? (addr_q[rd_ptr_q] + 32'd4) : 32'h0;

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized bench for instruction_fetch: an in-order memory with variable
// latency, random stall/redirect/reset, and a queue-based reference model
// of the fetch behaviour that predicts every output every cycle.
module tb_instruction_fetch;
  localparam int          MAXO = 3;
  localparam logic [31:0] RPC  = 32'h0000_0000;
  localparam int          NCYC = 4000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instruction_fetch_if bus();

  instruction_fetch #(.RESET_PC(RPC), .MAX_OUTSTANDING(MAXO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct { logic [31:0] addr; bit keep; } pend_t;
  typedef struct { logic [31:0] data; logic [31:0] addr; } inst_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int mode     = 0;
  int rst_cnt  = 0;
  int forced_rst = 0;

  // Reference model: PC, outstanding reads (live or to be dropped), buffer.
  pend_t       m_pend[$];
  inst_t       m_fifo[$];
  logic [31:0] m_pc;
  bit          m_hold;
  bit          m_redir;
  bit          exp_req;

  // Memory model.
  mreq_t       mem_q[$];
  bit          mem_real;
  bit          dut_req;
  logic [31:0] dut_addr;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] a);
    if (a == 32'h0) return 32'h2008_0005;
    if (a == 32'h4) return 32'h2009_0007;
    return (a * 32'h9E37_79B1) ^ 32'hDEAD_0000;
  endfunction

  function automatic int live_count();
    int n = 0;
    foreach (m_pend[i]) if (m_pend[i].keep) n++;
    return n;
  endfunction

  task automatic model_reset();
    m_pc    = RPC;
    m_pend.delete();
    m_fifo.delete();
    m_hold  = 1'b1;
    m_redir = 1'b0;
    mem_q.delete();
  endtask

  function automatic bit chance(input int pct);
    return $urandom_range(0, 99) < pct;
  endfunction

  task automatic drive_inputs();
    int stall_pct, ready_pct, redir_pct;
    if (mode != 0 && forced_rst < 3 && cyc > 200 && rst_cnt == 0 &&
        m_fifo.size() >= MAXO - 1 && m_pend.size() > 0) begin
      rst_cnt = 1;
      forced_rst++;
    end else if (mode != 0 && rst_cnt == 0 && $urandom_range(0, 399) == 0) begin
      rst_cnt = 1 + int'($urandom_range(0, 1));
    end
    rst = (rst_cnt > 0) ? 1'b0 : 1'b1;
    if (rst_cnt > 0) rst_cnt--;

    case (mode)
      0:       begin stall_pct = 0;  ready_pct = 100; redir_pct = 0;  end
      1:       begin stall_pct = 25; ready_pct = 75;  redir_pct = 4;  end
      2:       begin stall_pct = 90; ready_pct = 80;  redir_pct = 2;  end
      3:       begin stall_pct = 20; ready_pct = 20;  redir_pct = 3;  end
      default: begin stall_pct = 30; ready_pct = 70;  redir_pct = 20; end
    endcase
    bus.stall        = chance(stall_pct);
    bus.memReadReady = chance(ready_pct);
    bus.redirect     = chance(redir_pct);
    case ($urandom_range(0, 3))
      0:       bus.redirectAddress = 32'h0000_0103;
      1:       bus.redirectAddress = 32'hFFFF_FFFC;
      2:       bus.redirectAddress = 32'hFFFF_FFF6;
      default: bus.redirectAddress = $urandom;
    endcase

    mem_real = (mem_q.size() > 0) && (mem_q[0].due <= cyc) &&
               (mode == 0 || $urandom_range(0, 3) != 0);
    if (mem_real) begin
      bus.memReadValid = 1'b1;
      bus.memReadData  = word_of(mem_q[0].addr);
    end else begin
      // Occasional stray response with nothing outstanding must be ignored.
      bus.memReadValid = (mem_q.size() == 0) && ($urandom_range(0, 39) == 0);
      bus.memReadData  = $urandom;
    end
  endtask

  task automatic compare_outputs();
    logic [31:0] e_data, e_addr, e_next;
    bit          e_vld;
    exp_req = !m_hold && !m_redir && !bus.redirect &&
              (live_count() + m_fifo.size() < MAXO);
    e_vld  = (m_fifo.size() > 0);
    e_data = e_vld ? m_fifo[0].data : 32'h0;
    e_addr = e_vld ? m_fifo[0].addr : 32'h0;
    e_next = e_vld ? m_fifo[0].addr + 32'd4 : 32'h0;
    check_val("memReadRequest", {31'd0, bus.memReadRequest}, {31'd0, exp_req});
    if (exp_req) check_val("memAddress", bus.memAddress, m_pc);
    check_val("instructionValid", {31'd0, bus.instructionValid}, {31'd0, e_vld});
    check_val("instructionData", bus.instructionData, e_data);
    check_val("instructionAddress", bus.instructionAddress, e_addr);
    check_val("nextPCAddress", bus.nextPCAddress, e_next);
    dut_req  = bus.memReadRequest;
    dut_addr = bus.memAddress;
  endtask

  task automatic advance();
    pend_t p;
    bit    do_pop;
    if (!rst) begin
      model_reset();
      return;
    end
    // Memory side follows what the DUT actually did.
    if (mem_real) void'(mem_q.pop_front());
    if (dut_req && bus.memReadReady) begin
      mem_q.push_back('{addr: dut_addr,
                        due: cyc + 1 + ((mode == 0) ? 0 : int'($urandom_range(0, 2)))});
    end
    // Reference model follows its own prediction.
    if (bus.redirect) begin
      if (bus.memReadValid && m_pend.size() > 0) void'(m_pend.pop_front());
      foreach (m_pend[i]) m_pend[i].keep = 1'b0;
      m_fifo.delete();
      m_pc    = {bus.redirectAddress[31:2], 2'b00};
      m_redir = 1'b1;
      m_hold  = 1'b0;
    end else begin
      do_pop = (m_fifo.size() > 0) && !bus.stall;
      if (do_pop) void'(m_fifo.pop_front());
      if (bus.memReadValid && m_pend.size() > 0) begin
        p = m_pend.pop_front();
        if (p.keep) m_fifo.push_back('{data: bus.memReadData, addr: p.addr});
      end
      if (exp_req && bus.memReadReady) begin
        m_pend.push_back('{addr: m_pc, keep: 1'b1});
        m_pc = m_pc + 32'd4;
      end
      m_redir = 1'b0;
      m_hold  = 1'b0;
    end
  endtask

  initial begin
    rst                 = 1'b0;
    bus.stall           = 1'b0;
    bus.redirect        = 1'b0;
    bus.redirectAddress = 32'h0;
    bus.memReadReady    = 1'b0;
    bus.memReadValid    = 1'b0;
    bus.memReadData     = 32'h0;
    @(posedge clk);
    #1;
    model_reset();
    rst_cnt = 2;
    for (int c = 0; c < NCYC; c++) begin
      cyc = c;
      if (c % 25 == 0) mode = (c < 50) ? 0 : int'($urandom_range(0, 4));
      drive_inputs();
      #1;
      compare_outputs();
      @(posedge clk);
      #1;
      advance();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset; bits [1:0] SHALL be zero.
REQ-002 Parameter MAX_OUTSTANDING, default 2, max in-flight memory reads plus buffered instructions; legal range 1..4.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 memReadRequest  out  1  read request to instruction memory.
REQ-006 memAddress  out  32  word-aligned fetch address, valid while memReadRequest=1.
REQ-007 memReadReady  in  1  memory accepts request this cycle.
REQ-008 memReadValid  in  1  read data returned this cycle; responses in request order, latency >=1 cycle.
REQ-009 memReadData  in  32  returned instruction word.
REQ-010 stall  in  1  decode/Control stage cannot accept an instruction this cycle.
REQ-011 redirect  in  1  branch/jump taken; flush and refetch.
REQ-012 redirectAddress  in  32  new PC on redirect.
REQ-013 instructionData  out  32  instruction word to Control stage.
REQ-014 instructionAddress  out  32  address of instructionData.
REQ-015 nextPCAddress  out  32  instructionAddress+4, for link writeback.
REQ-016 instructionValid  out  1  instructionData/instructionAddress/nextPCAddress are valid.

Function
REQ-017 Request accepted when memReadRequest=1 and memReadReady=1; PC SHALL then advance by 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-018 Returned words SHALL enter a MAX_OUTSTANDING-deep FIFO holding {data, address}; head drives instructionData/instructionAddress.
REQ-019 Instruction consumed when instructionValid=1 and stall=0; FIFO pops in that cycle.
REQ-020 memReadRequest SHALL assert only in state FETCH, with redirect=0 and (inFlight + fifoCount) < MAX_OUTSTANDING.
REQ-021 memAddress and memReadRequest SHALL hold stable while memReadRequest=1 and memReadReady=0.
REQ-022 instructionValid = FIFO non-empty; when 0, instructionData SHALL read 32'h0 (NOP) and instructionAddress/nextPCAddress SHALL read 0.
REQ-023 Latency: with memory latency L and no stall, a word SHALL be visible on outputs the cycle after memReadValid.
REQ-024 States: RESET_HOLD (first cycle after rst release, no request) -> FETCH; FETCH -> REDIRECT on redirect=1; REDIRECT -> FETCH after one cycle.
REQ-025 On redirect=1: FIFO flushed next cycle; PC <= {redirectAddress[31:2], 2'b00}; discard counter <= in-flight count, including any request being accepted that cycle.
REQ-026 While discard counter >0, each memReadValid SHALL be dropped and decrement it; memReadValid in the same cycle as redirect SHALL also be dropped.
REQ-027 REDIRECT state SHALL issue no request; first request to new PC SHALL occur in the following FETCH cycle.
REQ-028 redirect SHALL take priority over stall, push, and pop in the same cycle; instructionValid SHALL be 0 the cycle after redirect.
REQ-029 Simultaneous push and pop with FIFO full SHALL be legal and keep count unchanged.
REQ-030 memReadValid while no non-discarded request is in flight is a protocol error; it SHALL be ignored.

Reset
REQ-031 With rst=0 at a rising edge: PC=RESET_PC, FIFO empty, inFlight=0, discard=0, state=RESET_HOLD.
REQ-032 During and the cycle after reset: memReadRequest=0, instructionValid=0, instructionData=0, instructionAddress=0, nextPCAddress=0.
REQ-033 Reset mid-operation SHALL abandon in-flight reads; stale responses after reset are ignored per REQ-030.

Verification
REQ-034 Reset release, memReadReady=1, latency 1, words 0x20080005,0x20090007 -> outputs addr 0x0 then 0x4 with those words, nextPCAddress 0x4 then 0x8.
REQ-035 stall=1 held 5 cycles with memory ready -> exactly MAX_OUTSTANDING requests issued, head unchanged, no word lost after stall drops.
REQ-036 redirect to 0x0000_0103 with 2 reads in flight -> next fetch address 0x100, both old responses dropped, first valid instruction has address 0x100.
REQ-037 memReadReady=0 for 3 cycles -> memAddress stable, PC not advanced, single request accepted on fourth cycle.
REQ-038 redirect to 0xFFFF_FFFC -> fetches 0xFFFF_FFFC then 0x0000_0000; nextPCAddress of first = 0x0.
REQ-039 rst=0 asserted with FIFO full and a read in flight -> all outputs zero next cycle; fetch restarts at RESET_PC.
